// File: rtl/from_udp_noc_rx_pkg.sv
// Shared UDP receive message types: NoC header flit, metadata flit and the
// metadata record handed to the UDP consumer. Flit structures sit in the
// most significant bits of a NoC flit.
package from_udp_noc_rx_pkg;

  localparam int MSG_LENGTH_WIDTH = 22;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;

  typedef struct packed {
    logic [7:0]                  dst_x;
    logic [7:0]                  dst_y;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len;
    logic [7:0]                  msg_type;
  } udp_noc_hdr_flit;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_rx_metadata_flit;

  localparam int HDR_FLIT_W  = $bits(udp_noc_hdr_flit);
  localparam int META_FLIT_W = $bits(udp_rx_metadata_flit);

  function automatic logic [MSG_LENGTH_WIDTH-1:0] hdr_msg_len(input udp_noc_hdr_flit hdr);
    return hdr.msg_len;
  endfunction

  function automatic udp_info meta_to_info(input udp_rx_metadata_flit meta);
    udp_info info;
    info.src_ip      = meta.src_ip;
    info.dst_ip      = meta.dst_ip;
    info.src_port    = meta.src_port;
    info.dst_port    = meta.dst_port;
    info.data_length = meta.data_length;
    return info;
  endfunction

endpackage

// File: rtl/from_udp_noc_rx_ctrl.sv
// Message framing FSM for the UDP receive path: accepts the header, then the
// metadata flit, offers metadata downstream, then passes payload flits through
// while counting them against the header length.
module from_udp_noc_rx_ctrl
  import from_udp_noc_rx_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        noc_val,
  input  logic [MSG_LENGTH_WIDTH-1:0] hdr_len,
  input  logic                        meta_rdy,
  input  logic                        data_rdy,
  output logic                        noc_rdy,
  output logic                        meta_val,
  output logic                        data_val,
  output logic                        data_last,
  output logic                        meta_capture,
  output logic [MSG_LENGTH_WIDTH-1:0] msg_len
);

  typedef enum logic [1:0] {RX_HDR, RX_META, META_OUT, RX_DATA} rx_state_e;

  rx_state_e                   state;
  logic [MSG_LENGTH_WIDTH-1:0] flit_cnt;
  logic                        in_data;
  logic                        data_xfer;

  assign in_data      = (state == RX_DATA);
  assign noc_rdy      = (state == RX_HDR) || (state == RX_META) || (in_data && data_rdy);
  assign meta_val     = (state == META_OUT);
  assign data_val     = in_data && noc_val;
  assign data_xfer    = data_val && data_rdy;
  assign data_last    = in_data && (flit_cnt == msg_len - MSG_LENGTH_WIDTH'(2));
  assign meta_capture = (state == RX_META) && noc_val;

  // State, stored message length and payload flit counter advance on handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_HDR;
      flit_cnt <= '0;
      msg_len  <= '0;
    end else begin
      case (state)
        RX_HDR: begin
          if (noc_val) begin
            msg_len <= hdr_len;
            if (hdr_len != '0) state <= RX_META;
          end
        end
        RX_META: begin
          if (noc_val) begin
            flit_cnt <= '0;
            state    <= META_OUT;
          end
        end
        META_OUT: begin
          if (meta_rdy) state <= (msg_len > MSG_LENGTH_WIDTH'(1)) ? RX_DATA : RX_HDR;
        end
        RX_DATA: begin
          if (data_xfer) begin
            if (data_last) state <= RX_HDR;
            else flit_cnt <= flit_cnt + MSG_LENGTH_WIDTH'(1);
          end
        end
        default: state <= RX_HDR;
      endcase
    end
  end

endmodule

// File: rtl/from_udp_noc_rx.sv
// UDP receive adapter from the NoC: splits an inbound NoC message into a
// metadata record and a stream of payload flits with last/padbytes marking,
// and flags messages whose data_length disagrees with the header length.
module from_udp_noc_rx
  import from_udp_noc_rx_pkg::*;
#(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES   = NOC_DATA_W/8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      noc_ctovr_fr_udp_val,
  input  logic [NOC_DATA_W-1:0]     noc_ctovr_fr_udp_data,
  output logic                      fr_udp_noc_ctovr_rdy,
  output logic                      fr_udp_dst_meta_val,
  output udp_info                   fr_udp_dst_meta_info,
  input  logic                      fr_udp_dst_meta_rdy,
  output logic                      fr_udp_dst_data_val,
  output logic [NOC_DATA_W-1:0]     fr_udp_dst_data,
  output logic                      fr_udp_dst_data_last,
  output logic [NOC_PADBYTES_W-1:0] fr_udp_dst_data_padbytes,
  input  logic                      fr_udp_dst_data_rdy,
  output logic                      fr_udp_len_err
);

  localparam int DL_W = 17;

  udp_noc_hdr_flit             hdr_view;
  udp_rx_metadata_flit         meta_view;
  udp_info                     meta_reg;
  logic [MSG_LENGTH_WIDTH-1:0] msg_len;
  logic                        meta_capture;
  logic                        data_last;
  logic [DL_W-1:0]             flit_need;
  logic [DL_W-1:0]             tail_bytes;
  logic [DL_W-1:0]             pad_bytes;
  logic                        len_mismatch;

  assign hdr_view  = udp_noc_hdr_flit'(noc_ctovr_fr_udp_data[NOC_DATA_W-1 -: HDR_FLIT_W]);
  assign meta_view = udp_rx_metadata_flit'(noc_ctovr_fr_udp_data[NOC_DATA_W-1 -: META_FLIT_W]);

  from_udp_noc_rx_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .noc_val      (noc_ctovr_fr_udp_val),
    .hdr_len      (hdr_msg_len(hdr_view)),
    .meta_rdy     (fr_udp_dst_meta_rdy),
    .data_rdy     (fr_udp_dst_data_rdy),
    .noc_rdy      (fr_udp_noc_ctovr_rdy),
    .meta_val     (fr_udp_dst_meta_val),
    .data_val     (fr_udp_dst_data_val),
    .data_last    (data_last),
    .meta_capture (meta_capture),
    .msg_len      (msg_len)
  );

  // Payload flits implied by data_length versus flits the header announced
  assign flit_need    = ({1'b0, meta_view.data_length} + DL_W'(NOC_PADBYTES - 1)) / DL_W'(NOC_PADBYTES);
  assign len_mismatch = (MSG_LENGTH_WIDTH'(flit_need) != (msg_len - MSG_LENGTH_WIDTH'(1)));

  assign tail_bytes = {1'b0, meta_reg.data_length} % DL_W'(NOC_PADBYTES);
  assign pad_bytes  = (DL_W'(NOC_PADBYTES) - tail_bytes) % DL_W'(NOC_PADBYTES);

  assign fr_udp_dst_meta_info     = meta_reg;
  assign fr_udp_dst_data          = noc_ctovr_fr_udp_data;
  assign fr_udp_dst_data_last     = data_last;
  assign fr_udp_dst_data_padbytes = data_last ? NOC_PADBYTES_W'(pad_bytes) : '0;

  // Capture metadata and raise a one-cycle length error when it arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg       <= '0;
      fr_udp_len_err <= 1'b0;
    end else begin
      fr_udp_len_err <= meta_capture && len_mismatch;
      if (meta_capture) meta_reg <= meta_to_info(meta_view);
    end
  end

endmodule
